// File: rtl/board_level_stream_symbol_encoder.sv
// ============================================================================
// Module      : board_level_stream_symbol_encoder
// Description : Framed raw-data stream to (DATA_W+2)-bit line symbol encoder
//               with registered output stage, IDLE gap and length policing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_level_stream_symbol_encoder #(
    parameter int DATA_W  = 6,
    parameter int GAP_LEN = 2,
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [DATA_W-1:0]   in_data,
    output logic [DATA_W+1:0]   out_symbol,
    output logic                out_wr,
    input  logic                out_full,
    output logic                in_frame,
    output logic                err_proto,
    output logic                err_len,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int SYM_W = DATA_W + 2;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = (GAP_LEN < 1) ? 1 : $clog2(GAP_LEN + 1);

    localparam logic [SYM_W-1:0] c_sym_idle = '0;
    localparam logic [SYM_W-1:0] c_sym_sof  = SYM_W'(1);
    localparam logic [SYM_W-1:0] c_sym_eof  = SYM_W'(2);
    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SYM_W-1:0]   r_sym;
    logic               r_vld;
    logic [LEN_W-1:0]   r_len;
    logic               r_over;
    logic [GAP_W-1:0]   r_gap;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_proto;
    logic               r_err_len;

    logic               w_slot_free;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_wr;
    logic               w_load;
    logic [SYM_W-1:0]   w_sym;
    logic               w_proto;
    logic               w_len_err;
    logic [LEN_W-1:0]   w_len_nx;
    logic               w_over_nx;
    logic [GAP_W-1:0]   w_gap_nx;

    // The slot frees either when empty or when its symbol leaves this cycle.
    assign w_slot_free = ~r_vld | ~out_full;
    assign w_in_ready  = w_slot_free & (r_state != S_GAP);
    assign w_accept    = in_valid & w_in_ready;
    assign w_wr        = r_vld & ~out_full;

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_sym     = c_sym_idle;
        w_proto   = 1'b0;
        w_len_err = 1'b0;
        w_len_nx  = r_len;
        w_over_nx = r_over;
        w_gap_nx  = r_gap;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_load    = 1'b1;
                        w_sym     = c_sym_sof;
                        w_len_nx  = '0;
                        w_over_nx = 1'b0;
                        w_next    = S_FRAME;
                    end else begin
                        w_proto = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_load    = 1'b1;
                        w_sym     = c_sym_sof;
                        w_len_nx  = '0;
                        w_over_nx = 1'b0;
                        w_proto   = 1'b1;
                    end else if (in_eof) begin
                        w_load   = 1'b1;
                        w_sym    = c_sym_eof;
                        w_gap_nx = '0;
                        w_next   = (GAP_LEN == 0) ? S_IDLE : S_GAP;
                    end else if (r_len < c_max_len) begin
                        w_load   = 1'b1;
                        w_sym    = {in_data, 2'b11};
                        w_len_nx = r_len + LEN_W'(1);
                    end else if (!r_over) begin
                        // Only the first overflowing word of a frame is flagged.
                        w_len_err = 1'b1;
                        w_over_nx = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_slot_free) begin
                    w_load = 1'b1;
                    w_sym  = c_sym_idle;
                    if (r_gap == c_gap_last) begin
                        w_gap_nx = '0;
                        w_next   = S_IDLE;
                    end else begin
                        w_gap_nx = r_gap + GAP_W'(1);
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sym       <= '0;
            r_vld       <= 1'b0;
            r_len       <= '0;
            r_over      <= 1'b0;
            r_gap       <= '0;
            r_cnt       <= '0;
            r_err_proto <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_len       <= w_len_nx;
            r_over      <= w_over_nx;
            r_gap       <= w_gap_nx;
            r_err_proto <= w_proto;
            r_err_len   <= w_len_err;
            if (w_load) begin
                r_sym <= w_sym;
                r_vld <= 1'b1;
            end else if (w_wr) begin
                r_vld <= 1'b0;
            end
            if (w_wr && (r_sym == c_sym_eof)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_symbol = r_sym;
    assign out_wr     = w_wr;
    assign in_frame   = (r_state == S_FRAME);
    assign err_proto  = r_err_proto;
    assign err_len    = r_err_len;
    assign frame_cnt  = r_cnt;

endmodule

`default_nettype wire
